eth_gt_link_ctrl: RTL

ETH_GT_LINK_CTRL -- requirements
Module: eth_gt_link_ctrl

---
 rtl/eth_gt_link_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/eth_gt_link_ctrl.sv
// Ethernet GT link bring-up controller.
// Sequences a multi-lane transceiver through reset, waits for per-lane reset
// done and PHY block lock, supervises the link while up, and retries bring-up
// on timeouts until a retry limit parks the link in FAIL.
module eth_gt_link_ctrl #(
    parameter int NUM_LANES    = 4,
    parameter int RESET_CYCLES = 1024,
    parameter int TIMER_WIDTH  = 24,
    parameter int LOCK_TIMEOUT = 1000000,
    parameter int MAX_RETRIES  = 3,
    parameter int DROP_CYCLES  = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 pll_locked,
    input  logic [NUM_LANES-1:0] lane_enable,
    input  logic                 force_reset,
    input  logic [NUM_LANES-1:0] gt_tx_done,
    input  logic [NUM_LANES-1:0] gt_rx_done,
    input  logic [NUM_LANES-1:0] rx_block_lock,
    output logic                 gt_reset_all,
    output logic [NUM_LANES-1:0] lane_up,
    output logic                 link_up,
    output logic                 link_fail,
    output logic [2:0]           state,
    output logic [3:0]           retry_count,
    output logic [15:0]          drop_count
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_WAIT_LOCK = 3'd3,
        ST_UP        = 3'd4,
        ST_FAIL      = 3'd5
    } state_t;

    localparam logic [TIMER_WIDTH-1:0] TIMER_ONE  = TIMER_WIDTH'(1);
    localparam logic [TIMER_WIDTH-1:0] RESET_LAST = TIMER_WIDTH'(RESET_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] LOCK_LAST  = TIMER_WIDTH'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_WIDTH-1:0] DROP_LAST  = TIMER_WIDTH'(DROP_CYCLES - 1);
    localparam logic [3:0]             RETRY_MAX  = 4'(MAX_RETRIES);

    state_t                 state_q, state_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic [TIMER_WIDTH-1:0] loss_q, loss_d;
    logic [3:0]             retry_q, retry_d;
    logic [15:0]            drop_q, drop_d;

    // Two-flop synchroniser stages for the asynchronous lane status inputs
    logic [NUM_LANES-1:0]   tx_done_p0, tx_done_p1;
    logic [NUM_LANES-1:0]   rx_done_p0, rx_done_p1;
    logic [NUM_LANES-1:0]   lock_p0, lock_p1;

    logic                   all_done;
    logic                   all_good;
    logic [3:0]             retry_inc;

    // Disabled lanes are treated as always satisfied
    assign all_done  = &(~lane_enable | (tx_done_p1 & rx_done_p1));
    assign all_good  = &(~lane_enable | (tx_done_p1 & rx_done_p1 & lock_p1));
    assign retry_inc = retry_q + 4'd1;

    // Bring lane status into the clk domain through two flops
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tx_done_p0 <= '0;
            tx_done_p1 <= '0;
            rx_done_p0 <= '0;
            rx_done_p1 <= '0;
            lock_p0    <= '0;
            lock_p1    <= '0;
        end else begin
            tx_done_p0 <= gt_tx_done;
            tx_done_p1 <= tx_done_p0;
            rx_done_p0 <= gt_rx_done;
            rx_done_p1 <= rx_done_p0;
            lock_p0    <= rx_block_lock;
            lock_p1    <= lock_p0;
        end
    end

    // Next-state, timer, loss counter and retry/drop bookkeeping
    always_comb begin
        state_d = state_q;
        timer_d = '0;
        loss_d  = '0;
        retry_d = retry_q;
        drop_d  = drop_q;
        if (!pll_locked) begin
            // Losing the clock source overrides everything else
            state_d = ST_IDLE;
        end else if (force_reset && (state_q != ST_IDLE)) begin
            state_d = ST_RESET;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (lane_enable != '0) state_d = ST_RESET;
                end
                ST_RESET: begin
                    if (timer_q == RESET_LAST) state_d = ST_WAIT_DONE;
                    else                       timer_d = timer_q + TIMER_ONE;
                end
                ST_WAIT_DONE: begin
                    // A satisfied exit condition beats a coincident timeout
                    if (all_done) begin
                        state_d = ST_WAIT_LOCK;
                    end else if (timer_q == LOCK_LAST) begin
                        retry_d = retry_inc;
                        state_d = (retry_inc == RETRY_MAX) ? ST_FAIL : ST_RESET;
                    end else begin
                        timer_d = timer_q + TIMER_ONE;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (all_good) begin
                        state_d = ST_UP;
                        retry_d = '0;
                    end else if (timer_q == LOCK_LAST) begin
                        retry_d = retry_inc;
                        state_d = (retry_inc == RETRY_MAX) ? ST_FAIL : ST_RESET;
                    end else begin
                        timer_d = timer_q + TIMER_ONE;
                    end
                end
                ST_UP: begin
                    if (!all_good) begin
                        if (loss_q == DROP_LAST) begin
                            state_d = ST_RESET;
                            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
                        end else begin
                            loss_d = loss_q + TIMER_ONE;
                        end
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Timer, loss counter and link statistics registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            timer_q <= '0;
            loss_q  <= '0;
            retry_q <= '0;
            drop_q  <= '0;
        end else begin
            timer_q <= timer_d;
            loss_q  <= loss_d;
            retry_q <= retry_d;
            drop_q  <= drop_d;
        end
    end

    // Status outputs registered alongside the state so they track it exactly
    always_ff @(posedge clk) begin
        if (!resetn) begin
            gt_reset_all <= 1'b1;
            link_up      <= 1'b0;
            link_fail    <= 1'b0;
            lane_up      <= '0;
        end else begin
            gt_reset_all <= (state_d == ST_IDLE) || (state_d == ST_RESET) ||
                            (state_d == ST_FAIL);
            link_up      <= (state_d == ST_UP);
            link_fail    <= (state_d == ST_FAIL);
            lane_up      <= lane_enable & tx_done_p1 & rx_done_p1 & lock_p1;
        end
    end

    assign state       = state_q;
    assign retry_count = retry_q;
    assign drop_count  = drop_q;

endmodule
